// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the icache/dcache to single-RAM-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;

  localparam logic [31:0] ARB_TIMEOUT_WORD = 32'hBAD1BAD1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRESP = 3'd3,
    IRESP = 3'd4
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  typedef struct packed {
    arb_op_t                 op;
    logic [ARB_ADDR_W-1:0]   addr;
    logic [ARB_DATA_W-1:0]   data;
  } arb_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and RAM-side signal bundle of the memory arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramrdy;

  logic              arb_err;

  // Arbiter side
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  // Caches and RAM side
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramrdy,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

endinterface

// File: rtl/mem_arbiter_timeout_ctr.sv
// Access-cycle watchdog; built only with MEM_ARBITER_TIMEOUT_EN defined.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  // Fires during the TIMEOUT-th access cycle so the abort lands on its closing edge
  assign o_expire_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en && !o_expire_c) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache reads and dcache reads/writes onto one RAM port, data first.
// Optional access watchdog enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic           CLK,
  input  logic           nRST,
  mem_arbiter_if.slave   bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT must be at least 1");
  end

  arb_state_t        r_state, w_state_nx;
  arb_req_t          r_req, w_req_nx;
  logic              r_ram_ren, w_ram_ren_nx;
  logic              r_ram_wen, w_ram_wen_nx;
  logic              r_iwait, w_iwait_nx;
  logic              r_dwait, w_dwait_nx;
  logic [DATA_W-1:0] r_iload, w_iload_nx;
  logic [DATA_W-1:0] r_dload, w_dload_nx;
  logic              r_err, w_err_nx;
  logic              w_expire;

`ifdef MEM_ARBITER_TIMEOUT_EN
  logic w_in_acc;

  assign w_in_acc = (r_state == DACC) || (r_state == IACC);

  arb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk        (CLK),
    .rst_n      (nRST),
    .i_load     (!w_in_acc),
    .i_en       (w_in_acc),
    .o_expire_c (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  assign bus.ramREN   = r_ram_ren;
  assign bus.ramWEN   = r_ram_wen;
  assign bus.ramaddr  = ADDR_W'(r_req.addr);
  assign bus.ramstore = DATA_W'(r_req.data);
  assign bus.iwait    = r_iwait;
  assign bus.dwait    = r_dwait;
  assign bus.iload    = r_iload;
  assign bus.dload    = r_dload;
  assign bus.arb_err  = r_err;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_ram_ren <= 1'b0;
      r_ram_wen <= 1'b0;
      r_iwait   <= 1'b1;
      r_dwait   <= 1'b1;
      r_iload   <= '0;
      r_dload   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_req     <= w_req_nx;
      r_ram_ren <= w_ram_ren_nx;
      r_ram_wen <= w_ram_wen_nx;
      r_iwait   <= w_iwait_nx;
      r_dwait   <= w_dwait_nx;
      r_iload   <= w_iload_nx;
      r_dload   <= w_dload_nx;
      r_err     <= w_err_nx;
    end
  end

  // Wait pulses are set on the completion edge, so they are low exactly in RESP
  always_comb begin
    w_state_nx   = r_state;
    w_req_nx     = r_req;
    w_ram_ren_nx = r_ram_ren;
    w_ram_wen_nx = r_ram_wen;
    w_iwait_nx   = 1'b1;
    w_dwait_nx   = 1'b1;
    w_iload_nx   = r_iload;
    w_dload_nx   = r_dload;
    w_err_nx     = r_err;

    case (r_state)
      IDLE: begin
        if (bus.dREN || bus.dWEN) begin
          w_req_nx.op   = bus.dWEN ? OP_WRITE : OP_READ;
          w_req_nx.addr = ARB_ADDR_W'(bus.daddr);
          w_req_nx.data = ARB_DATA_W'(bus.dstore);
          w_ram_ren_nx  = !bus.dWEN;
          w_ram_wen_nx  = bus.dWEN;
          if (bus.dREN && bus.dWEN) begin
            w_err_nx = 1'b1;
          end
          w_state_nx = DACC;
        end else if (bus.iREN) begin
          w_req_nx.op   = OP_READ;
          w_req_nx.addr = ARB_ADDR_W'(bus.iaddr);
          w_req_nx.data = '0;
          w_ram_ren_nx  = 1'b1;
          w_ram_wen_nx  = 1'b0;
          w_state_nx    = IACC;
        end
      end

      DACC: begin
        if (bus.ramrdy || w_expire) begin
          w_ram_ren_nx = 1'b0;
          w_ram_wen_nx = 1'b0;
          if (!bus.ramrdy) begin
            w_dload_nx = DATA_W'(ARB_TIMEOUT_WORD);
            w_err_nx   = 1'b1;
          end else if (r_req.op == OP_READ) begin
            w_dload_nx = bus.ramload;
          end
          w_dwait_nx = !(bus.dREN || bus.dWEN);
          w_state_nx = DRESP;
        end
      end

      IACC: begin
        if (bus.ramrdy || w_expire) begin
          w_ram_ren_nx = 1'b0;
          w_ram_wen_nx = 1'b0;
          if (!bus.ramrdy) begin
            w_iload_nx = DATA_W'(ARB_TIMEOUT_WORD);
            w_err_nx   = 1'b1;
          end else begin
            w_iload_nx = bus.ramload;
          end
          w_iwait_nx = !bus.iREN;
          w_state_nx = IRESP;
        end
      end

      DRESP, IRESP: begin
        w_state_nx = IDLE;
      end

      default: begin
        w_state_nx   = IDLE;
        w_ram_ren_nx = 1'b0;
        w_ram_wen_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, memory model and per-scenario tasks.
module tb_mem_arbiter;

  logic CLK;
  logic nRST;

  int total;
  int bad;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM contents seen by the responder, and the bench's own view of memory
  logic [31:0] ram_mem   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];
  logic        log_we   [$];
  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  int   ram_lat;
  int   ram_busy;
  logic ram_en;
  logic force_rdy;

  logic [31:0] exp_iload;
  logic [31:0] exp_dload;
  logic        exp_err;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  function automatic logic [31:0] rd_ram(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    ram_mem[a]   = d;
    model_mem[a] = d;
  endtask

  // RAM responder: completes a strobed access after ram_lat extra cycles
  initial begin
    bus.ramrdy  = 1'b0;
    bus.ramload = '0;
    ram_busy    = 0;
    forever begin
      @(negedge CLK);
      if (!nRST) begin
        bus.ramrdy = 1'b0;
        ram_busy   = 0;
      end else if (bus.ramrdy) begin
        bus.ramrdy = 1'b0;
      end else if (force_rdy) begin
        bus.ramrdy  = 1'b1;
        bus.ramload = 32'h0BADF00D;
        force_rdy   = 1'b0;
      end else if ((bus.ramREN || bus.ramWEN) && ram_en) begin
        if (ram_busy >= ram_lat) begin
          ram_busy   = 0;
          bus.ramrdy = 1'b1;
          if (bus.ramWEN) begin
            ram_mem[bus.ramaddr] = bus.ramstore;
            bus.ramload = $urandom;
          end else begin
            bus.ramload = rd_ram(bus.ramaddr);
          end
          log_we.push_back(bus.ramWEN);
          log_addr.push_back(bus.ramaddr);
          log_data.push_back(bus.ramWEN ? bus.ramstore : bus.ramload);
        end else begin
          ram_busy++;
        end
      end else begin
        ram_busy = 0;
      end
    end
  end

  task automatic clear_reqs();
    bus.iREN   = 1'b0;
    bus.iaddr  = '0;
    bus.dREN   = 1'b0;
    bus.dWEN   = 1'b0;
    bus.daddr  = '0;
    bus.dstore = '0;
  endtask

  // kind: 0 iread, 1 dread, 2 dwrite, 3 dREN+dWEN together
  task automatic run_access(input int kind, input logic [31:0] addr,
                            input logic [31:0] data, input int lat);
    int   cyc;
    int   lidx;
    logic seen;
    logic other_low;
    logic is_d;
    logic is_wr;
    logic [31:0] exp_log;
    is_d  = (kind != 0);
    is_wr = (kind >= 2);
    ram_lat = lat;
    lidx = log_we.size();
    if (kind == 0) begin
      bus.iREN  = 1'b1;
      bus.iaddr = addr;
    end else begin
      bus.dREN   = (kind != 2);
      bus.dWEN   = is_wr;
      bus.daddr  = addr;
      bus.dstore = data;
    end
    if (kind == 3) exp_err = 1'b1;
    cyc = 0; seen = 1'b0; other_low = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        total++;
        if ({bus.ramREN, bus.ramWEN} !== {!is_wr, is_wr}) begin
          bad++; $display("FAIL strobe k=%0d: got %b want %b", kind, {bus.ramREN, bus.ramWEN}, {!is_wr, is_wr});
        end
        total++;
        if (bus.ramaddr !== addr) begin
          bad++; $display("FAIL ramaddr: got %h want %h", bus.ramaddr, addr);
        end
        if (is_wr) begin
          total++;
          if (bus.ramstore !== data) begin
            bad++; $display("FAIL ramstore: got %h want %h", bus.ramstore, data);
          end
        end
      end
      if ((is_d ? bus.iwait : bus.dwait) !== 1'b1) other_low = 1'b1;
      if ((is_d ? bus.dwait : bus.iwait) === 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen || cyc != lat + 2) begin
      bad++; $display("FAIL latency k=%0d: got %0d cycles (seen=%b) want %0d", kind, cyc, seen, lat + 2);
    end
    if (seen) begin
      if (kind == 0)      exp_iload = rd_model(addr);
      else if (kind == 1) exp_dload = rd_model(addr);
      else                model_mem[addr] = data;
      total++;
      if (is_d ? (bus.dload !== exp_dload) : (bus.iload !== exp_iload)) begin
        bad++; $display("FAIL load k=%0d: got %h want %h", kind, is_d ? bus.dload : bus.iload,
                        is_d ? exp_dload : exp_iload);
      end
      total++;
      if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
        bad++; $display("FAIL strobe_drop: got %b%b want 00", bus.ramREN, bus.ramWEN);
      end
    end
    clear_reqs();
    @(negedge CLK);
    total++;
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
      bad++; $display("FAIL pulse_width: got i=%b d=%b want 1 1", bus.iwait, bus.dwait);
    end
    total++;
    if (other_low !== 1'b0) begin
      bad++; $display("FAIL other_wait: got low want high");
    end
    total++;
    if (bus.arb_err !== exp_err) begin
      bad++; $display("FAIL arb_err: got %b want %b", bus.arb_err, exp_err);
    end
    total++;
    exp_log = is_wr ? data : rd_model(addr);
    if (log_we.size() != lidx + 1) begin
      bad++; $display("FAIL ram_log_len: got %0d want %0d", log_we.size(), lidx + 1);
    end else if (log_we[lidx] !== is_wr || log_addr[lidx] !== addr || log_data[lidx] !== exp_log) begin
      bad++; $display("FAIL ram_log: got we=%b a=%h d=%h want we=%b a=%h d=%h",
                      log_we[lidx], log_addr[lidx], log_data[lidx], is_wr, addr, exp_log);
    end
  endtask

  task automatic test_reset();
    int viol;
    clear_reqs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
    total++;
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
      bad++; $display("FAIL rst_wait: got i=%b d=%b want 1 1", bus.iwait, bus.dwait);
    end
    total++;
    if (bus.iload !== 32'h0 || bus.dload !== 32'h0) begin
      bad++; $display("FAIL rst_load: got %h %h want 0 0", bus.iload, bus.dload);
    end
    total++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0) begin
      bad++; $display("FAIL rst_ram: got %b%b %h %h want 00 0 0", bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore);
    end
    total++;
    if (bus.arb_err !== 1'b0) begin
      bad++; $display("FAIL rst_err: got %b want 0", bus.arb_err);
    end
    nRST = 1'b1;
    viol = 0;
    repeat (10) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN || !bus.iwait || !bus.dwait) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL idle_quiet: got %0d active cycles want 0", viol);
    end
  endtask

  task automatic test_iread_directed();
    preload(32'h40, 32'h8C010004);
    run_access(0, 32'h40, 32'h0, 0);
  endtask

  task automatic test_random(input int n);
    int kind;
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 2);
      a    = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      run_access(kind, a, $urandom, $urandom_range(0, 3));
    end
  endtask

  task automatic test_priority();
    int   dcyc;
    int   icyc;
    int   lidx;
    logic idle_gap;
    logic iacc_ok;
    ram_lat = 0;
    lidx = log_we.size();
    bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF;
    bus.iREN = 1'b1; bus.iaddr = 32'h200;
    dcyc = 0; icyc = 0; idle_gap = 1'b0; iacc_ok = 1'b0;
    for (int c = 1; c <= 12 && icyc == 0; c++) begin
      @(negedge CLK);
      if (c == 3 && !bus.ramREN && !bus.ramWEN) idle_gap = 1'b1;
      if (c == 4 && bus.ramREN && bus.ramaddr == 32'h200) iacc_ok = 1'b1;
      if (bus.dwait === 1'b0 && dcyc == 0) begin dcyc = c; bus.dWEN = 1'b0; end
      if (bus.iwait === 1'b0) begin icyc = c; bus.iREN = 1'b0; end
    end
    model_mem[32'h100] = 32'hDEADBEEF;
    exp_iload = rd_model(32'h200);
    total++;
    if (dcyc != 2 || icyc != 5) begin
      bad++; $display("FAIL prio_order: got d=%0d i=%0d want d=2 i=5", dcyc, icyc);
    end
    total++;
    if (idle_gap !== 1'b1 || iacc_ok !== 1'b1) begin
      bad++; $display("FAIL prio_gap: got gap=%b iacc=%b want 1 1", idle_gap, iacc_ok);
    end
    total++;
    if (bus.iload !== exp_iload) begin
      bad++; $display("FAIL prio_iload: got %h want %h", bus.iload, exp_iload);
    end
    total++;
    if (log_we.size() != lidx + 2) begin
      bad++; $display("FAIL prio_log_len: got %0d want %0d", log_we.size(), lidx + 2);
    end else if (log_we[lidx] !== 1'b1 || log_addr[lidx] !== 32'h100 || log_data[lidx] !== 32'hDEADBEEF ||
                 log_we[lidx+1] !== 1'b0 || log_addr[lidx+1] !== 32'h200) begin
      bad++; $display("FAIL prio_log: got %b/%h/%h then %b/%h want 1/100/deadbeef then 0/200",
                      log_we[lidx], log_addr[lidx], log_data[lidx], log_we[lidx+1], log_addr[lidx+1]);
    end
    @(negedge CLK);
  endtask

  task automatic test_withdraw();
    int   acc;
    int   lidx;
    logic low;
    ram_lat = 5;
    lidx = log_we.size();
    bus.dREN = 1'b1; bus.daddr = 32'h3C;
    acc = 0; low = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge CLK);
      if (c == 2) bus.dREN = 1'b0;
      if (bus.ramREN) acc++;
      if (bus.dwait === 1'b0) low = 1'b1;
    end
    exp_dload = rd_model(32'h3C);
    total++;
    if (acc != 6) begin
      bad++; $display("FAIL wd_access_len: got %0d want 6", acc);
    end
    total++;
    if (low !== 1'b0) begin
      bad++; $display("FAIL wd_no_pulse: got pulse want none");
    end
    total++;
    if (bus.dload !== exp_dload || log_we.size() != lidx + 1) begin
      bad++; $display("FAIL wd_complete: got %h/%0d want %h/%0d", bus.dload, log_we.size(), exp_dload, lidx + 1);
    end
  endtask

  task automatic test_back_to_back();
    int pulses[$];
    ram_lat = 0;
    bus.dREN = 1'b1; bus.daddr = 32'h80;
    for (int c = 1; c <= 8; c++) begin
      @(negedge CLK);
      if (bus.dwait === 1'b0) pulses.push_back(c);
    end
    clear_reqs();
    @(negedge CLK);
    exp_dload = rd_model(32'h80);
    total++;
    if (pulses.size() != 3) begin
      bad++; $display("FAIL b2b_count: got %0d pulses want 3", pulses.size());
    end else if (pulses[0] != 2 || pulses[1] != 5 || pulses[2] != 8) begin
      bad++; $display("FAIL b2b_spacing: got %0d,%0d,%0d want 2,5,8", pulses[0], pulses[1], pulses[2]);
    end
    total++;
    if (bus.dload !== exp_dload || bus.dwait !== 1'b1) begin
      bad++; $display("FAIL b2b_end: got %h/%b want %h/1", bus.dload, bus.dwait, exp_dload);
    end
  endtask

  task automatic test_ramrdy_ignored();
    int viol;
    viol = 0;
    force_rdy = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      if (bus.ramREN || bus.ramWEN || !bus.iwait || !bus.dwait ||
          bus.iload !== exp_iload || bus.dload !== exp_dload) viol++;
    end
    total++;
    if (viol != 0) begin
      bad++; $display("FAIL idle_ramrdy: got %0d disturbed cycles want 0", viol);
    end
  endtask

  task automatic test_both_err();
    run_access(3, 32'h24, 32'hCAFE0001, 1);
    test_random(6);
  endtask

  task automatic test_reset_mid_access();
    ram_en = 1'b0;
    bus.dREN = 1'b1; bus.daddr = 32'h44;
    repeat (3) @(negedge CLK);
    total++;
    if (bus.ramREN !== 1'b1) begin
      bad++; $display("FAIL rma_active: got %b want 1", bus.ramREN);
    end
    nRST = 1'b0;
    @(negedge CLK);
    exp_iload = '0; exp_dload = '0; exp_err = 1'b0;
    total++;
    if ({bus.ramREN, bus.ramWEN} !== 2'b00 || bus.dwait !== 1'b1 || bus.dload !== 32'h0 || bus.arb_err !== 1'b0) begin
      bad++; $display("FAIL rma_reset: got %b%b w=%b %h e=%b want 00 w=1 0 e=0",
                      bus.ramREN, bus.ramWEN, bus.dwait, bus.dload, bus.arb_err);
    end
    nRST = 1'b1;
    clear_reqs();
    ram_en = 1'b1;
    @(negedge CLK);
    run_access(1, 32'h44, 32'h0, 1);
  endtask

`ifdef MEM_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    int   cyc;
    logic seen;
    ram_en = 1'b0;
    bus.dREN = 1'b1; bus.daddr = 32'h48;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge CLK);
      cyc++;
      if (bus.dwait === 1'b0) seen = 1'b1;
    end
    total++;
    if (!seen || cyc != 9) begin
      bad++; $display("FAIL tmo_latency: got %0d (seen=%b) want 9", cyc, seen);
    end
    total++;
    if (bus.dload !== 32'hBAD1BAD1 || bus.arb_err !== 1'b1) begin
      bad++; $display("FAIL tmo_result: got %h e=%b want bad1bad1 e=1", bus.dload, bus.arb_err);
    end
    clear_reqs();
    @(negedge CLK);
    ram_en = 1'b1;
    exp_dload = 32'hBAD1BAD1;
    exp_err   = 1'b1;
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    ram_lat = 0; ram_en = 1'b1; force_rdy = 1'b0;
    nRST = 1'b0;
    clear_reqs();
    test_reset();
    test_iread_directed();
    test_random(20);
    test_priority();
    test_withdraw();
    test_back_to_back();
    test_ramrdy_ignored();
    test_both_err();
    test_reset_mid_access();
`ifdef MEM_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    test_random(8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
